sram_port_arbiter: RTL

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_arb_pkg.sv | 12 +
 rtl/sram_port_arbiter_if.sv | 34 +++
 rtl/sram_arb_rd_tag_pipe.sv | 26 ++
 rtl/sram_port_arbiter.sv | 74 +++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared constants and read-tag types for the two-port SRAM arbiter
package sram_arb_pkg;
  localparam int NUM_REQ = 2;
  typedef logic req_id_t;
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;
  function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
    return NUM_REQ'(1) << id;
  endfunction
endpackage

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: requester handshake and SRAM bus of the two-port arbiter
//   requester side: rq_req/rq_write/rq_addr*/rq_byteen*/rq_wdata* in, rq_ack/rq_rvalid/rq_rdata out
//   memory side: mem_ren/mem_wen/mem_addr/mem_byteen/mem_wdata out, mem_rdata in
interface sram_port_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int MEM_AWIDTH = 16
);
  logic [NUM_REQ-1:0]    rq_req;
  logic [NUM_REQ-1:0]    rq_write;
  logic [MEM_AWIDTH-1:0] rq_addr0;
  logic [MEM_AWIDTH-1:0] rq_addr1;
  logic [3:0]            rq_byteen0;
  logic [3:0]            rq_byteen1;
  logic [31:0]           rq_wdata0;
  logic [31:0]           rq_wdata1;
  logic [NUM_REQ-1:0]    rq_ack;
  logic [NUM_REQ-1:0]    rq_rvalid;
  logic [31:0]           rq_rdata;
  logic                  mem_ren;
  logic                  mem_wen;
  logic [MEM_AWIDTH-1:0] mem_addr;
  logic [3:0]            mem_byteen;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  modport master (
    output rq_req, rq_write, rq_addr0, rq_addr1, rq_byteen0, rq_byteen1, rq_wdata0, rq_wdata1, mem_rdata,
    input  rq_ack, rq_rvalid, rq_rdata, mem_ren, mem_wen, mem_addr, mem_byteen, mem_wdata
  );
  modport slave (
    input  rq_req, rq_write, rq_addr0, rq_addr1, rq_byteen0, rq_byteen1, rq_wdata0, rq_wdata1, mem_rdata,
    output rq_ack, rq_rvalid, rq_rdata, mem_ren, mem_wen, mem_addr, mem_byteen, mem_wdata
  );
endinterface

// File: rtl/sram_arb_rd_tag_pipe.sv
// sram_arb_rd_tag_pipe: RD_LATENCY+1 deep read-tag shift register
//   tag_i: tag of the read on the SRAM bus this cycle; cap_en_o: mem_rdata valid now; rvalid_o: per-requester return pulse
module sram_arb_rd_tag_pipe
  import sram_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic               HCLK,
  input  logic               HRESETN,
  input  rd_tag_t            tag_i,
  output logic               cap_en_o,
  output logic [NUM_REQ-1:0] rvalid_o
);
  rd_tag_t tag_q [RD_LATENCY+1];
  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      for (int i = 0; i <= RD_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_i;
      for (int i = 1; i <= RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end
  // stage k holds a read issued k+1 cycles ago
  assign cap_en_o = tag_q[RD_LATENCY-1].valid;
  assign rvalid_o = tag_q[RD_LATENCY].valid ? id_onehot(tag_q[RD_LATENCY].id) : '0;
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin arbiter sharing one single-port SRAM between two requesters
//   HCLK/HRESETN: clock and sync active-low reset; bus: requester handshake plus registered SRAM strobes
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int MEM_AWIDTH = 16,
  parameter int RD_LATENCY = 1
) (
  input logic                HCLK,
  input logic                HRESETN,
  sram_port_arbiter_if.slave bus
);
  logic [NUM_REQ-1:0]    elig, ack_q, ack_d;
  logic                  any_elig, sel_wr, ren_q, ren_d, wen_q, wen_d, ptr_q, ptr_d, cap_en;
  req_id_t               gid, id_q, id_d;
  logic [MEM_AWIDTH-1:0] addr_q, addr_d;
  logic [3:0]            byteen_q, byteen_d;
  logic [31:0]           wdata_q, wdata_d, rdata_q, rdata_d;
  rd_tag_t               tag;
  always_comb begin
    // a requester whose ack is out this cycle is still showing the old request
    elig     = bus.rq_req & ~ack_q;
    any_elig = |elig;
    gid      = &elig ? ptr_q : elig[1];
    sel_wr   = bus.rq_write[gid];
    ack_d    = any_elig ? id_onehot(gid) : '0;
    ren_d    = any_elig & ~sel_wr;
    wen_d    = any_elig & sel_wr;
    id_d     = any_elig ? gid : id_q;
    addr_d   = any_elig ? (gid ? bus.rq_addr1 : bus.rq_addr0) : addr_q;
    byteen_d = any_elig ? (sel_wr ? (gid ? bus.rq_byteen1 : bus.rq_byteen0) : 4'b0000) : byteen_q;
    wdata_d  = any_elig ? (gid ? bus.rq_wdata1 : bus.rq_wdata0) : wdata_q;
    ptr_d    = &elig ? ~ptr_q : ptr_q;
    rdata_d  = cap_en ? bus.mem_rdata : rdata_q;
  end
  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      ack_q    <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      id_q     <= 1'b0;
      addr_q   <= '0;
      byteen_q <= '0;
      wdata_q  <= '0;
      ptr_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ack_q    <= ack_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      byteen_q <= byteen_d;
      wdata_q  <= wdata_d;
      ptr_q    <= ptr_d;
      rdata_q  <= rdata_d;
    end
  end
  assign tag = '{valid: ren_q, id: id_q};
  sram_arb_rd_tag_pipe #(.RD_LATENCY(RD_LATENCY)) u_tag_pipe (
    .HCLK    (HCLK),
    .HRESETN (HRESETN),
    .tag_i   (tag),
    .cap_en_o(cap_en),
    .rvalid_o(bus.rq_rvalid)
  );
  assign bus.rq_ack     = ack_q;
  assign bus.rq_rdata   = rdata_q;
  assign bus.mem_ren    = ren_q;
  assign bus.mem_wen    = wen_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_byteen = byteen_q;
  assign bus.mem_wdata  = wdata_q;
endmodule
